mult_share_arbiter: RTL and testbench

- Shares one signed integer multiplier datapath among N_REQ requesters.
- Datapath: W_IN_A x W_IN_B two's-complement operands in, W_IN_A+W_IN_B two's-complement product out, computed by sign-magnitude.
- Arbitration is round-robin over per-requester valid/ready ports.
- The block wraps the multiplier in a 2-stage registered pipeline with output backpressure and returns each product tagged with the ID of the requester that issued it.

---
 rtl/mult_share_arbiter.sv | 124 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one signed sign-magnitude multiplier among N_REQ requesters.
// Two registered stages (S1 operands, output product) with full output backpressure.
module mult_share_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int W_IN_A  = 8,
    parameter  int W_IN_B  = 16,
    localparam int W_ID    = $clog2(N_REQ),
    localparam int W_OUT_X = W_IN_A + W_IN_B
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*W_IN_A-1:0]   req_a,
    input  logic [N_REQ*W_IN_B-1:0]   req_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W_OUT_X-1:0]        out_x,
    output logic [W_ID-1:0]           out_id,
    output logic                      busy
);

    logic [W_ID-1:0]    ptr_q, ptr_d;
    logic               s1_valid_q, s1_valid_d;
    logic [W_IN_A-1:0]  s1_a_q, s1_a_d;
    logic [W_IN_B-1:0]  s1_b_q, s1_b_d;
    logic [W_ID-1:0]    s1_id_q, s1_id_d;
    logic               out_valid_q, out_valid_d;
    logic [W_OUT_X-1:0] out_x_q, out_x_d;
    logic [W_ID-1:0]    out_id_q, out_id_d;

    logic               out_adv, s1_adv;
    logic               grant_vld;
    logic [W_ID-1:0]    grant_idx;
    int                 scan;

    logic               sign_x;
    logic [W_IN_A-1:0]  mag_a;
    logic [W_IN_B-1:0]  mag_b;
    logic [W_OUT_X-1:0] mag_x, prod;

    assign out_adv = !out_valid_q | out_ready;
    assign s1_adv  = !s1_valid_q | out_adv;

    // Scan from the far end back toward the pointer so the last hit is the first at/after it.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan = int'(ptr_q) + k;
            if (scan >= N_REQ) scan = scan - N_REQ;
            if (req_valid[W_ID'(scan)]) begin
                grant_vld = 1'b1;
                grant_idx = W_ID'(scan);
            end
        end
        if (!s1_adv || rst) grant_vld = 1'b0;
    end

    assign req_ready = grant_vld ? (N_REQ'(1) << grant_idx) : '0;

    // Negation at operand width maps the most-negative value to its correct unsigned magnitude.
    always_comb begin
        sign_x = s1_a_q[W_IN_A-1] ^ s1_b_q[W_IN_B-1];
        mag_a  = s1_a_q[W_IN_A-1] ? -s1_a_q : s1_a_q;
        mag_b  = s1_b_q[W_IN_B-1] ? -s1_b_q : s1_b_q;
        mag_x  = W_OUT_X'(mag_a) * W_OUT_X'(mag_b);
        prod   = sign_x ? -mag_x : mag_x;
    end

    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_id_d    = out_id_q;
        if (out_adv) begin
            out_valid_d = s1_valid_q;
            out_x_d     = prod;
            out_id_d    = s1_id_q;
        end
        if (s1_adv) begin
            s1_valid_d = grant_vld;
            if (grant_vld) begin
                s1_a_d  = req_a[grant_idx*W_IN_A +: W_IN_A];
                s1_b_d  = req_b[grant_idx*W_IN_B +: W_IN_B];
                s1_id_d = grant_idx;
                ptr_d   = (grant_idx == W_ID'(N_REQ - 1)) ? '0 : grant_idx + W_ID'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_id    = out_id_q;
    assign busy      = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: operand table, directed arbitration/stall/reset
// sequences, and randomized traffic against a slot-level reference model.
module tb_mult_share_arbiter;

    localparam int N  = 4;
    localparam int WA = 8;
    localparam int WB = 16;
    localparam int WX = WA + WB;
    localparam int WI = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*WA-1:0] req_a;
    logic [N*WB-1:0] req_b;
    logic            out_valid;
    logic            out_ready;
    logic [WX-1:0]   out_x;
    logic [WI-1:0]   out_id;
    logic            busy;

    mult_share_arbiter #(.N_REQ(N), .W_IN_A(WA), .W_IN_B(WB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_id(out_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: two slots (waiting, presented) plus the round-robin pointer.
    int            m_ptr;
    bit            m_s1_v, m_out_v, m_can;
    logic [WX-1:0] m_s1_x, m_out_x;
    int            m_s1_id, m_out_id;
    int            m_g;

    typedef struct {
        logic [WA-1:0] a;
        logic [WB-1:0] b;
        logic [WX-1:0] x;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [WX-1:0] ref_mul(input logic [WA-1:0] a, input logic [WB-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[WX-1:0];
    endfunction

    task automatic set_req(input int i, input logic [WA-1:0] a, input logic [WB-1:0] b);
        req_a[i*WA +: WA] = a;
        req_b[i*WB +: WB] = b;
    endtask

    task automatic model_clear();
        m_ptr = 0; m_s1_v = 0; m_out_v = 0;
        m_s1_x = '0; m_out_x = '0; m_s1_id = 0; m_out_id = 0;
    endtask

    // Compare every output with the model at the falling edge.
    task automatic sample();
        int idx;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        m_can = !rst && (!m_s1_v || !m_out_v || out_ready);
        m_g = -1;
        if (m_can)
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (m_g < 0 && req_valid[idx]) m_g = idx;
            end
        exp_rdy = '0;
        if (m_g >= 0) exp_rdy[m_g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("out_valid", out_valid, m_out_v);
        chk("busy", busy, m_s1_v | m_out_v);
        if (m_out_v) begin
            chk("out_x", out_x, m_out_x);
            chk("out_id", out_id, m_out_id);
        end
    endtask

    task automatic adv();
        if (rst) model_clear();
        else begin
            if (!m_out_v || out_ready) begin
                m_out_v = m_s1_v; m_out_x = m_s1_x; m_out_id = m_s1_id;
            end
            if (m_can) begin
                m_s1_v = (m_g >= 0);
                if (m_g >= 0) begin
                    m_s1_x  = ref_mul(req_a[m_g*WA +: WA], req_b[m_g*WB +: WB]);
                    m_s1_id = m_g;
                    m_ptr   = (m_g + 1) % N;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        sample();
        adv();
        rst = 1'b0;
    endtask

    function automatic logic [WA-1:0] rnd_a();
        case ($urandom_range(4))
            0: return 8'h80;
            1: return 8'h7F;
            default: return WA'($urandom);
        endcase
    endfunction

    function automatic logic [WB-1:0] rnd_b();
        case ($urandom_range(4))
            0: return 16'h8000;
            1: return 16'h7FFF;
            default: return WB'($urandom);
        endcase
    endfunction

    initial begin
        logic [WX-1:0] hold_x;
        logic [WI-1:0] hold_id;
        int acc;

        tbl[0] = '{8'h03, 16'hFFFB, 24'hFFFFF1};
        tbl[1] = '{8'h80, 16'h8000, 24'h400000};
        tbl[2] = '{8'h80, 16'h7FFF, 24'hC00080};
        tbl[3] = '{8'h7F, 16'hFFFF, 24'hFFFF81};
        tbl[4] = '{8'h00, 16'h8000, 24'h000000};
        tbl[5] = '{8'hFF, 16'hFFFF, 24'h000001};
        tbl[6] = '{8'h7F, 16'h7FFF, 24'h3F7F81};
        tbl[7] = '{8'h80, 16'h0001, 24'hFFFF80};

        rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        sample();
        chk("rst_out_x", out_x, 0);
        chk("rst_out_id", out_id, 0);
        adv();
        rst = 1'b0;
        req_valid = '0;

        // Operand table: one request at a time, result two cycles after the grant.
        for (int i = 0; i < 8; i++) begin
            set_req(i % N, tbl[i].a, tbl[i].b);
            req_valid = '0;
            req_valid[i % N] = 1'b1;
            sample();
            chk("tbl_grant", req_ready, req_valid);
            adv();
            req_valid = '0;
            sample();
            chk("tbl_lat1", out_valid, 0);
            adv();
            sample();
            chk("tbl_valid", out_valid, 1);
            chk("tbl_x", out_x, tbl[i].x);
            chk("tbl_id", out_id, i % N);
            adv();
        end

        // Round-robin streaming with no bubbles.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, rnd_a(), rnd_b());
        req_valid = '1;
        for (int t = 0; t < 8; t++) begin
            sample();
            if (t < 6) chk("rr_grant", req_ready, 64'd1 << (t % N));
            if (t >= 2) begin
                chk("rr_outv", out_valid, 1);
                chk("rr_outid", out_id, (t - 2) % N);
            end
            adv();
        end

        // Output stall: exactly two accepts, stable output, then in-order drain.
        do_reset();
        out_ready = 1'b0;
        req_valid = '1;
        acc = 0;
        for (int t = 0; t < 5; t++) begin
            sample();
            if (req_ready != '0) acc++;
            if (t == 2) begin hold_x = out_x; hold_id = out_id; end
            if (t > 2) begin
                chk("stall_x", out_x, hold_x);
                chk("stall_id", out_id, hold_id);
            end
            if (t == 4) chk("stall_rdy", req_ready, 0);
            adv();
        end
        chk("stall_accepts", acc, 2);
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            sample();
            chk("drain_v", out_valid, 1);
            chk("drain_id", out_id, t % N);
            adv();
        end

        // Pointer at 2 with only requesters 0 and 3 asking.
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0010;
        sample();
        chk("ptr_g1", req_ready, 4'b0010);
        adv();
        req_valid = 4'b1001;
        sample();
        chk("ptr_g3", req_ready, 4'b1000);
        adv();
        sample();
        chk("ptr_g0", req_ready, 4'b0001);
        adv();

        // Reset with both stages full.
        do_reset();
        out_ready = 1'b0;
        req_valid = '1;
        repeat (2) begin sample(); adv(); end
        sample();
        chk("full_busy", busy, 1);
        chk("full_v", out_valid, 1);
        adv();
        rst = 1'b1;
        sample();
        chk("rst_rdy", req_ready, 0);
        adv();
        rst = 1'b0;
        req_valid = 4'b0110;
        sample();
        chk("post_rst_v", out_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_grant", req_ready, 4'b0010);
        adv();

        // Randomized traffic; requesters hold operands until their transfer.
        req_valid = '0;
        for (int t = 0; t < 600; t++) begin
            rst = ($urandom_range(99) == 0);
            out_ready = ($urandom_range(9) < 7);
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(1) == 1) begin
                    set_req(i, rnd_a(), rnd_b());
                    req_valid[i] = 1'b1;
                end
            sample();
            adv();
            if (m_g >= 0) begin
                req_valid[m_g] = ($urandom_range(1) == 1);
                set_req(m_g, rnd_a(), rnd_b());
            end
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
